// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    // Responder control states: accepting, counting latency, presenting a response.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    localparam int BE_W       = 4;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with one byte-enable write port and an
// asynchronous read port. Each byte lane is its own array so that a
// lane write never touches its neighbours.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [BE_W-1:0]      be,
    input  logic [IDX_W-1:0]     widx,
    input  logic [31:0]          wdata,
    input  logic [IDX_W-1:0]     ridx,
    output logic [31:0]          rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < BE_W; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];

            // Clear the lane on reset; otherwise write it when its enable is set.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH_WORDS; i++) begin
                        lane_mem[i] <= '0;
                    end
                end else if (we && be[gi]) begin
                    lane_mem[widx] <= wdata[8*gi +: 8];
                end
            end

            assign rdata[8*gi +: 8] = lane_mem[ridx];
        end
    endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits a fixed
// number of cycles, commits the access to the array on the edge that enters
// RESP and holds the response until the core takes it.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [BE_W-1:0]  req_be,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err
);

    localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * WORD_BYTES);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
    localparam bit          LAT_ONE  = (LATENCY == 1);

    dmem_state_e state_reg, state_next;
    logic [3:0]      cnt_reg;
    logic            lat_we_reg;
    logic [31:0]     lat_addr_reg;
    logic [31:0]     lat_wdata_reg;
    logic [BE_W-1:0] lat_be_reg;
    logic [31:0]     rsp_rdata_reg;
    logic            rsp_err_reg;

    logic            accept;
    logic            commit;
    logic            cmt_we;
    logic [31:0]     cmt_addr;
    logic [31:0]     cmt_wdata;
    logic [BE_W-1:0] cmt_be;
    logic [31:0]     cmt_off;
    logic            cmt_err;
    logic            arr_we;
    logic [IDX_W-1:0] cmt_idx;
    logic [31:0]     arr_rdata;

    assign accept = (state_reg == IDLE) && req_valid;

    // With a one-cycle latency the commit edge is the accept edge, so the
    // commit path must see the live request rather than the latched copy.
    assign commit = (accept && LAT_ONE) || ((state_reg == WAIT) && (cnt_reg == 4'd1));

    assign cmt_we    = (state_reg == IDLE) ? req_we    : lat_we_reg;
    assign cmt_addr  = (state_reg == IDLE) ? req_addr  : lat_addr_reg;
    assign cmt_wdata = (state_reg == IDLE) ? req_wdata : lat_wdata_reg;
    assign cmt_be    = (state_reg == IDLE) ? req_be    : lat_be_reg;

    // Unsigned wrap-around makes addresses below the base land out of range.
    assign cmt_off = cmt_addr - BASE_ADDR;
    assign cmt_err = (cmt_addr[1:0] != 2'b00) || (cmt_off >= SPAN);
    assign cmt_idx = cmt_off[IDX_W+1:2];
    assign arr_we  = commit && cmt_we && !cmt_err;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (arr_we),
        .be    (cmt_be),
        .widx  (cmt_idx),
        .wdata (cmt_wdata),
        .ridx  (cmt_idx),
        .rdata (arr_rdata)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: accept in IDLE, count down in WAIT, release on handshake.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    state_next = LAT_ONE ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Latch the request and run the latency counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg       <= '0;
            lat_we_reg    <= 1'b0;
            lat_addr_reg  <= '0;
            lat_wdata_reg <= '0;
            lat_be_reg    <= '0;
        end else if (accept) begin
            cnt_reg       <= CNT_INIT;
            lat_we_reg    <= req_we;
            lat_addr_reg  <= req_addr;
            lat_wdata_reg <= req_wdata;
            lat_be_reg    <= req_be;
        end else if (state_reg == WAIT) begin
            cnt_reg <= cnt_reg - 4'd1;
        end
    end

    // Capture the response on the commit edge; it then holds through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else if (commit) begin
            rsp_rdata_reg <= (!cmt_we && !cmt_err) ? arr_rdata : 32'h0;
            rsp_err_reg   <= cmt_err;
        end
    end

    assign req_ready = (state_reg == IDLE);
    assign rsp_valid = (state_reg == RESP);
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance for the main
// sequence and a LATENCY=1 instance for back-to-back throughput.
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;

    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        req_valid1, req_ready1, req_we1;
    logic [31:0] req_addr1, req_wdata1;
    logic [3:0]  req_be1;
    logic        rsp_valid1, rsp_ready1, rsp_err1;
    logic [31:0] rsp_rdata1;

    int total = 0;
    int bad   = 0;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2), .BASE_ADDR(32'h0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1), .BASE_ADDR(32'h0)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
        .req_addr(req_addr1), .req_wdata(req_wdata1), .req_be(req_be1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
        .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction on the LATENCY=2 instance, rsp_ready held high.
    // lat counts cycles from the accept edge to the first rsp_valid.
    task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] rd, output logic e,
                        output int lat);
        req_we = we; req_addr = a; req_wdata = wd; req_be = be; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rsp_rdata;
        e  = rsp_err;
        $display("xact we=%0d addr=%h wdata=%h be=%h -> rdata=%h err=%0d lat=%0d",
                 we, a, wd, be, rd, e, lat);
        @(posedge clk); #1;
    endtask

    logic [31:0] rd;
    logic        e;
    int          lat;
    int          accepts;
    int          rsps;
    int          wcnt;

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        rsp_ready = 1'b1;
        req_valid1 = 1'b0; req_we1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; req_be1 = '0;
        rsp_ready1 = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err",   32'(rsp_err), 32'd0);

        // Full-word store then load
        xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e, lat);
        chk("st10_lat", 32'(lat), 32'd2);
        chk("st10_err", 32'(e), 32'd0);
        chk("st10_rdata", rd, 32'h0);
        xact(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
        chk("ld10_lat", 32'(lat), 32'd2);
        chk("ld10_rdata", rd, 32'hDEADBEEF);
        chk("ld10_err", 32'(e), 32'd0);

        // Partial-lane store merges with the existing word
        xact(1'b1, 32'h10, 32'h000055AA, 4'b0011, rd, e, lat);
        xact(1'b0, 32'h10, 32'h0, 4'hF, rd, e, lat);
        chk("ld10_merge", rd, 32'hDEAD55AA);

        // Misaligned load
        xact(1'b0, 32'h12, 32'h0, 4'hF, rd, e, lat);
        chk("ld12_err", 32'(e), 32'd1);
        chk("ld12_rdata", rd, 32'h0);

        // Out-of-range store must not alias onto word 0
        xact(1'b1, 32'h0, 32'h12345678, 4'hF, rd, e, lat);
        xact(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, rd, e, lat);
        chk("st400_err", 32'(e), 32'd1);
        chk("st400_rdata", rd, 32'h0);
        xact(1'b0, 32'h0, 32'h0, 4'hF, rd, e, lat);
        chk("ld0_unchanged", rd, 32'h12345678);

        // Address below base wraps and errors (base 0: wrap not possible, use top of space)
        xact(1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, rd, e, lat);
        chk("ldtop_err", 32'(e), 32'd1);

        // Store with no enables is a legal no-op
        xact(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, rd, e, lat);
        chk("stbe0_err", 32'(e), 32'd0);
        chk("stbe0_rdata", rd, 32'h0);
        xact(1'b0, 32'h10, 32'h0, 4'hF, rd, e, lat);
        chk("ld10_after_be0", rd, 32'hDEAD55AA);

        // Response backpressure: outputs hold, no new accept until after handshake
        rsp_ready = 1'b0;
        req_we = 1'b0; req_addr = 32'h10; req_be = 4'hF; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wcnt = 0;
        while (!rsp_valid && wcnt < 20) begin
            @(posedge clk); #1;
            wcnt++;
        end
        req_we = 1'b0; req_addr = 32'h0; req_be = 4'hF; req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            $display("hold cycle %0d: rsp_valid=%0d rdata=%h err=%0d req_ready=%0d",
                     k, rsp_valid, rsp_rdata, rsp_err, req_ready);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rdata", rsp_rdata, 32'hDEAD55AA);
            chk("hold_err", 32'(rsp_err), 32'd0);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("hs_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("hs_no_accept", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        chk("post_hs_accept", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        wcnt = 0;
        while (!rsp_valid && wcnt < 20) begin
            @(posedge clk); #1;
            wcnt++;
        end
        chk("post_hs_ld0", rsp_rdata, 32'h12345678);
        @(posedge clk); #1;

        // Reset during WAIT of a store drops it and clears the array
        req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_be = 4'hF; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("wait_req_ready", 32'(req_ready), 32'd0);
        chk("wait_rsp_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mrst_req_ready", 32'(req_ready), 32'd1);
        chk("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mrst_rsp_rdata", rsp_rdata, 32'h0);
        chk("mrst_rsp_err",   32'(rsp_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        xact(1'b0, 32'h20, 32'h0, 4'hF, rd, e, lat);
        chk("ld20_after_rst", rd, 32'h0);
        xact(1'b0, 32'h10, 32'h0, 4'hF, rd, e, lat);
        chk("ld10_after_rst", rd, 32'h0);

        // LATENCY=1 instance: store, then back-to-back loads
        req_we1 = 1'b1; req_addr1 = 32'h4; req_wdata1 = 32'hA5A5A5A5; req_be1 = 4'hF; req_valid1 = 1'b1;
        @(posedge clk); #1;
        req_valid1 = 1'b0;
        chk("l1_st_valid", 32'(rsp_valid1), 32'd1);
        chk("l1_st_err", 32'(rsp_err1), 32'd0);
        @(posedge clk); #1;
        req_we1 = 1'b0; req_addr1 = 32'h4; req_be1 = 4'hF; req_valid1 = 1'b1;
        accepts = 0;
        rsps = 0;
        for (int k = 0; k < 8; k++) begin
            if (req_ready1) accepts++;
            @(posedge clk); #1;
            $display("l1 cycle %0d: rsp_valid=%0d rdata=%h req_ready=%0d",
                     k, rsp_valid1, rsp_rdata1, req_ready1);
            if (rsp_valid1) begin
                rsps++;
                chk("l1_ld_rdata", rsp_rdata1, 32'hA5A5A5A5);
            end
        end
        req_valid1 = 1'b0;
        chk("l1_accepts", 32'(accepts), 32'd4);
        chk("l1_rsps", 32'(rsps), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder that serves load/store requests from the core's data-memory port over a valid/ready request channel and a valid/ready response channel. It owns a word-organised storage array with byte-enable writes, adds a fixed, parameterised access latency, and flags misaligned or out-of-range accesses. One transaction is outstanding at a time. It replaces the zero-latency data memory when the core is run against realistic memory timing.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words; power of two.
- LATENCY, 2: cycles from request accept to rsp_valid; legal range 1..15.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; DEPTH_WORDS*4-aligned.

- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, little-endian lanes
- req_be  in  4  byte enables; bit i writes req_wdata[8i+7:8i]
- rsp_valid  out  1  response present
- rsp_ready  in  1  core accepts response
- rsp_rdata  out  32  load data; 0 for stores and errors
- rsp_err  out  1  access was misaligned or out of range

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, latch we/addr/wdata/be and load the counter with LATENCY-1. Go to RESP if LATENCY==1, else WAIT.
- WAIT: req_ready=0. Decrement the counter each cycle. When the counter is 1, go to RESP on the next edge.
- On the edge entering RESP (the commit edge):
  - Compute off = req_addr - BASE_ADDR.
  - err = (addr[1:0]!=0) or (off >= DEPTH_WORDS*4).
  - Store without error: write the enabled lanes of word off[..:2].
  - Load without error: register the full word into rsp_rdata.
  - Error: no array change, rsp_rdata=0, rsp_err=1.
- RESP: rsp_valid=1. rsp_rdata and rsp_err stay stable until rsp_valid && rsp_ready. On that handshake, go to IDLE.
- Stores with req_be==0 are legal no-ops: rsp_err=0, rsp_rdata=0.
- req_ready is asserted only in IDLE. A request arriving in the cycle of the response handshake is not accepted until the next cycle.
- Loads ignore req_be and always return the full word. Sub-word extraction and sign extension are the core's job.
- Load immediately after a store to the same word returns the updated data, because the commit precedes any later accept.

## Timing
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0, all array words=0.
- Request handshake: req_valid && req_ready at a rising edge, cycle T.
- rsp_valid first high in cycle T+LATENCY; it stays high until rsp_ready is sampled high.
- Minimum period between accepts is LATENCY+1 cycles, with rsp_ready tied high.
- Reset mid-operation (WAIT or RESP): return to IDLE immediately and clear outputs and array. A pending store that has not reached its commit edge is dropped.
- Requester inputs are don't-care outside the accept cycle, since everything is latched.
- Out-of-range check uses the unsigned 32-bit subtraction. Addresses below BASE_ADDR wrap to large values and therefore error.

## Structure
- Package dmem_pkg:
  - state enum dmem_state_e {IDLE, WAIT, RESP}
  - localparam BE_W=4
  - localparam WORD_BYTES=4
- Sub-module dmem_array:
  - Synchronous byte-enable write port plus asynchronous read port.
  - Asynchronous reset clears all words to 0.
  - Ports: clk, rst_n, we, be[3:0], widx, wdata, ridx, rdata.
- Top level: FSM, latency counter, request latch, error check, response registers.

## Test plan
- LATENCY=2, store addr 0x10, wdata 0xDEADBEEF, be 4'hF, then load 0x10 → store rsp at T+2 with err=0, rdata=0; load rsp rdata=0xDEADBEEF.
- Store 0x10 wdata 0x000055AA, be 4'b0011 over 0xDEADBEEF → load returns 0xDEAD55AA.
- Load 0x12 → rsp_err=1, rdata=0. Store to DEPTH_WORDS*4 → rsp_err=1 and a following load of word 0 is unchanged.
- Hold rsp_ready=0 for 5 cycles after rsp_valid → rsp_valid, rdata and err stable. req_ready=0 throughout; a new req_valid is not accepted until the cycle after the handshake.
- Assert rst_n low in WAIT of a store to 0x20 → outputs return to reset values; a later load of 0x20 returns 0.
- LATENCY=1, back-to-back loads with rsp_ready=1 → rsp_valid in T+1; accepts occur every 2 cycles.
